sdram_rw_scheduler: RTL

//  Schedules SDRAM burst traffic between the camera write FIFO and the display read FIFO.

---
 rtl/sdram_rw_scheduler.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/sdram_rw_scheduler.sv
// ---------------------------------------------------------------------------
// sdram_rw_scheduler
//   Schedules SDRAM burst traffic between the camera write FIFO and the
//   display read FIFO. One burst is outstanding at a time. When both sides
//   need service, the side that was not served last wins (round-robin).
//   Frames ping-pong between banks 0 and 1. The writer never starts a new
//   frame in the bank that the reader is scanning mid-frame.
//
// Ports
//   S_CLK          clock, all logic on the rising edge
//   RST_N          asynchronous active-low reset
//   wr_fifo_usedw  camera-side FIFO fill level (a write burst is needed at >= BURST_LEN)
//   rd_fifo_usedw  display-side FIFO fill level (a read burst is needed below RD_LOW_WATER)
//   rd_enable      display consumer active; no new read bursts while low
//   write_en       write burst request, held until write_ack
//   write_ack      1-cycle pulse: write burst complete
//   read_en        read burst request, held until read_ack
//   read_ack       1-cycle pulse: read burst complete
//   addr           burst start word address, stable while a request is high
//   bank           bank of the current burst (0 or 1)
//   wr_frame_done  1-cycle pulse when the last write burst of a frame is acked
//   frame_valid    sticky: at least one complete frame has been written
//   busy           scheduler is not idle
// ---------------------------------------------------------------------------
module sdram_rw_scheduler #(
  parameter int BURST_LEN    = 256,
  parameter int FRAME_BURSTS = 1200,
  parameter int RD_LOW_WATER = 256,
  parameter int GAP_CYC      = 2
) (
  input  logic        S_CLK,
  input  logic        RST_N,
  input  logic [8:0]  wr_fifo_usedw,
  input  logic [8:0]  rd_fifo_usedw,
  input  logic        rd_enable,
  output logic        write_en,
  input  logic        write_ack,
  output logic        read_en,
  input  logic        read_ack,
  output logic [19:0] addr,
  output logic [1:0]  bank,
  output logic        wr_frame_done,
  output logic        frame_valid,
  output logic        busy
);

  localparam int CNT_W = (FRAME_BURSTS > 1) ? $clog2(FRAME_BURSTS) : 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  localparam logic [CNT_W-1:0] LAST_BURST = CNT_W'(FRAME_BURSTS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYC - 1);
  localparam logic [19:0]      ADDR_STEP  = 20'(BURST_LEN);
  localparam logic [9:0]       WR_THRESH  = 10'(BURST_LEN);
  localparam logic [9:0]       RD_THRESH  = 10'(RD_LOW_WATER);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_REQ = 2'd1,
    RD_REQ = 2'd2,
    GAP    = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] wr_cnt, rd_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             wr_bank, rd_bank, done_bank;
  logic             last_grant_rd;   // 1 = read was served last

  logic             wr_need, rd_need;
  logic             rd_bank_eff;
  logic [19:0]      wr_addr, rd_addr;

  assign wr_need = ({1'b0, wr_fifo_usedw} >= WR_THRESH);
  assign rd_need = rd_enable & frame_valid & ({1'b0, rd_fifo_usedw} < RD_THRESH);

  // A reader that is between frames always starts on the newest complete frame.
  assign rd_bank_eff = (rd_cnt == '0) ? done_bank : rd_bank;

  assign wr_addr = 20'(wr_cnt) * ADDR_STEP;
  assign rd_addr = 20'(rd_cnt) * ADDR_STEP;

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_need && (!rd_need || last_grant_rd)) state_nxt = WR_REQ;
        else if (rd_need)                          state_nxt = RD_REQ;
      end
      WR_REQ:  if (write_ack)            state_nxt = GAP;
      RD_REQ:  if (read_ack)             state_nxt = GAP;
      GAP:     if (gap_cnt == GAP_LAST)  state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge S_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      write_en      <= 1'b0;
      read_en       <= 1'b0;
      addr          <= '0;
      bank          <= '0;
      wr_frame_done <= 1'b0;
      frame_valid   <= 1'b0;
      wr_cnt        <= '0;
      rd_cnt        <= '0;
      gap_cnt       <= '0;
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      done_bank     <= 1'b0;
      last_grant_rd <= 1'b1;
    end else begin
      state         <= state_nxt;
      write_en      <= (state_nxt == WR_REQ);
      read_en       <= (state_nxt == RD_REQ);
      wr_frame_done <= 1'b0;
      gap_cnt       <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;

      if (state == IDLE && state_nxt == WR_REQ) begin
        addr <= wr_addr;
        bank <= {1'b0, wr_bank};
      end
      if (state == IDLE && state_nxt == RD_REQ) begin
        addr    <= rd_addr;
        bank    <= {1'b0, rd_bank_eff};
        rd_bank <= rd_bank_eff;
      end

      if (state == WR_REQ && write_ack) begin
        last_grant_rd <= 1'b0;
        if (wr_cnt == LAST_BURST) begin
          wr_cnt        <= '0;
          wr_frame_done <= 1'b1;
          frame_valid   <= 1'b1;
          done_bank     <= wr_bank;
          // Stay in place if the other bank is the one being read mid-frame.
          if (rd_cnt == '0 || (~wr_bank != rd_bank)) wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + CNT_W'(1);
        end
      end

      if (state == RD_REQ && read_ack) begin
        last_grant_rd <= 1'b1;
        if (rd_cnt == LAST_BURST) begin
          rd_cnt  <= '0;
          rd_bank <= done_bank;
        end else begin
          rd_cnt <= rd_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
